// File: rtl/instr_encoder_if.sv
// Operand-bundle handshake and IMEM write bus for the instruction encoder.
// The master side drives the mnemonic and operand fields. The slave side
// (the encoder) returns in_ready and drives the IMEM write port.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_addr;
  logic              imem_wren;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_addr,
    input  in_ready, imem_wren, imem_addr, imem_data
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_addr,
    output in_ready, imem_wren, imem_addr, imem_data
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs mnemonic + operand fields into 32-bit MIPS words and
// writes them to consecutive IMEM addresses, starting at start_addr.
// Optional feature macro: BRANCH_REL_EN. When it is defined, BEQ/BNE take an
// absolute target word address and encode it relative to the next address.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  instr_encoder_if.slave    bus,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] counter_q;
  logic [ADDR_W:0]   wc_q;
  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              full_q;
  logic              err_q;
  logic              done_q;

  logic              in_ready_s;
  logic              accept_s;
  logic              legal_s;
  logic              last_s;
  logic [15:0]       br_imm_s;
  logic [31:0]       enc_s;

  // Pack one instruction word. Forced-zero fields are applied here.
  function automatic logic [31:0] encode(
    input logic [4:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  sh,
    input logic [15:0] imm,
    input logic [15:0] br_imm,
    input logic [25:0] jaddr
  );
    logic [31:0] w;
    w = 32'h0000_0000;
    case (kind)
      5'd0:    w = {6'h00, 5'd0, rt, rd, sh, 6'h00};      // SLL
      5'd1:    w = {6'h00, 5'd0, rt, rd, sh, 6'h02};      // SRL
      5'd2:    w = {6'h00, 5'd0, rt, rd, sh, 6'h03};      // SRA
      5'd3:    w = {6'h00, rs, 15'd0, 6'h08};             // JR
      5'd4:    w = {6'h00, rs, rt, rd, 5'd0, 6'h20};      // ADD
      5'd5:    w = {6'h00, rs, rt, rd, 5'd0, 6'h21};      // ADDU
      5'd6:    w = {6'h00, rs, rt, rd, 5'd0, 6'h22};      // SUB
      5'd7:    w = {6'h00, rs, rt, rd, 5'd0, 6'h23};      // SUBU
      5'd8:    w = {6'h00, rs, rt, rd, 5'd0, 6'h24};      // AND
      5'd9:    w = {6'h00, rs, rt, rd, 5'd0, 6'h25};      // OR
      5'd10:   w = {6'h00, rs, rt, rd, 5'd0, 6'h26};      // XOR
      5'd11:   w = {6'h00, rs, rt, rd, 5'd0, 6'h27};      // NOR
      5'd12:   w = {6'h00, rs, rt, rd, 5'd0, 6'h2A};      // SLT
      5'd13:   w = {6'h02, jaddr};                        // J
      5'd14:   w = {6'h03, jaddr};                        // JAL
      5'd15:   w = {6'h04, rs, rt, br_imm};               // BEQ
      5'd16:   w = {6'h05, rs, rt, br_imm};               // BNE
      5'd17:   w = {6'h08, rs, rt, imm};                  // ADDI
      5'd18:   w = {6'h09, rs, rt, imm};                  // ADDIU
      5'd19:   w = {6'h0C, rs, rt, imm};                  // ANDI
      5'd20:   w = {6'h0D, rs, rt, imm};                  // ORI
      5'd21:   w = {6'h0E, rs, rt, imm};                  // XORI
      5'd22:   w = {6'h0F, 5'd0, rt, imm};                // LUI
      5'd23:   w = {6'h23, rs, rt, imm};                  // LW
      5'd24:   w = {6'h2B, rs, rt, imm};                  // SW
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Handshake qualifiers, branch offset, and the word for the current bundle.
  always_comb begin
    in_ready_s = (state_q == ST_RUN) && !start && !stop;
    accept_s   = bus.in_valid && in_ready_s;
    legal_s    = (bus.in_kind <= 5'd24);
    last_s     = (counter_q == {ADDR_W{1'b1}});
`ifdef BRANCH_REL_EN
    // The offset is relative to the address after the branch, taken mod 2**16.
    br_imm_s   = bus.in_imm - (16'(counter_q) + 16'd1);
`else
    br_imm_s   = bus.in_imm;
`endif
    enc_s      = encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                        bus.in_shamt, bus.in_imm, br_imm_s, bus.in_addr);
  end

  // Session FSM next state; start always wins over stop.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (accept_s && legal_s && last_s) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FULL: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, address counter, session status and the registered IMEM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      counter_q <= {ADDR_W{1'b0}};
      wc_q      <= {(ADDR_W+1){1'b0}};
      wren_q    <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      data_q    <= 32'h0000_0000;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wren_q  <= accept_s && legal_s;
      done_q  <= 1'b0;
      if (start) begin
        counter_q <= start_addr;
        wc_q      <= {(ADDR_W+1){1'b0}};
        err_q     <= 1'b0;
        full_q    <= 1'b0;
      end else if (stop && (state_q != ST_IDLE)) begin
        done_q <= 1'b1;
      end else if (accept_s) begin
        if (legal_s) begin
          addr_q <= counter_q;
          data_q <= enc_s;
          wc_q   <= wc_q + {{ADDR_W{1'b0}}, 1'b1};
          if (last_s) begin
            // The counter never wraps: it parks on the last address.
            full_q <= 1'b1;
          end else begin
            counter_q <= counter_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // A write still in flight when reset arrives never reaches the IMEM.
  assign bus.imem_wren = wren_q && !rst;
  assign bus.imem_addr = addr_q;
  assign bus.imem_data = data_q;
  assign bus.in_ready  = in_ready_s;
  assign word_count    = wc_q;
  assign full          = full_q;
  assign err           = err_q;
  assign done          = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 16-word IMEM (ADDR_W=4).
module tb_instr_encoder;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              stop;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              err;
  logic              done;

  int passed;
  int total;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .stop       (stop),
    .bus        (bus),
    .word_count (word_count),
    .full       (full),
    .err        (err),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] jaddr);
    bus.in_valid = 1'b1;
    bus.in_kind  = kind;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_shamt = sh;
    bus.in_imm   = imm;
    bus.in_addr  = jaddr;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; start_addr = 4'd0;
    bus.in_valid = 1'b0; bus.in_kind = 5'd0; bus.in_rs = 5'd0; bus.in_rt = 5'd0;
    bus.in_rd = 5'd0; bus.in_shamt = 5'd0; bus.in_imm = 16'h0; bus.in_addr = 26'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_wren", {31'd0, bus.imem_wren}, 32'd0);
    check("rst_addr", {28'd0, bus.imem_addr}, 32'd0);
    check("rst_data", bus.imem_data, 32'd0);
    check("rst_wc", {27'd0, word_count}, 32'd0);
    check("rst_flags", {28'd0, full, err, done, bus.in_ready}, 32'd0);

    // 1: session at 0, ADDU
    start = 1'b1; start_addr = 4'd0;
    #1;
    check("rdy_start", {31'd0, bus.in_ready}, 32'd0);
    tick();
    start = 1'b0;
    #1;
    check("rdy_run", {31'd0, bus.in_ready}, 32'd1);
    drive(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    tick();
    bus.in_valid = 1'b0;
    check("addu_wren", {31'd0, bus.imem_wren}, 32'd1);
    check("addu_addr", {28'd0, bus.imem_addr}, 32'd0);
    check("addu_data", bus.imem_data, 32'h0022_1821);
    check("addu_wc", {27'd0, word_count}, 32'd1);

    // 2: SLL with rs forced to zero
    drive(5'd0, 5'd7, 5'd5, 5'd4, 5'd2, 16'h0, 26'h0);
    tick();
    check("sll_addr", {28'd0, bus.imem_addr}, 32'd1);
    check("sll_data", bus.imem_data, 32'h0005_2080);

    // 3: LW then J back to back
    drive(5'd23, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
    tick();
    check("lw_addr", {28'd0, bus.imem_addr}, 32'd2);
    check("lw_data", bus.imem_data, 32'h8FA8_0004);
    drive(5'd13, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    tick();
    bus.in_valid = 1'b0;
    check("j_addr", {28'd0, bus.imem_addr}, 32'd3);
    check("j_data", bus.imem_data, 32'h0800_0010);
    tick();
    check("idle_wren", {31'd0, bus.imem_wren}, 32'd0);
    check("hold_data", bus.imem_data, 32'h0800_0010);

    // 4: illegal kind, then ADD at the unchanged address (shamt forced 0)
    drive(5'd31, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    tick();
    check("ill_wren", {31'd0, bus.imem_wren}, 32'd0);
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_wc", {27'd0, word_count}, 32'd4);
    drive(5'd4, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0);
    tick();
    check("add_addr", {28'd0, bus.imem_addr}, 32'd4);
    check("add_data", bus.imem_data, 32'h0022_1820);
    check("add_err", {31'd0, err}, 32'd1);

    // 6: BEQ at address 5
    drive(5'd15, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0003, 26'h0);
    tick();
    bus.in_valid = 1'b0;
    check("beq_addr", {28'd0, bus.imem_addr}, 32'd5);
`ifdef BRANCH_REL_EN
    check("beq_data", bus.imem_data, 32'h1022_FFFD);
`else
    check("beq_data", bus.imem_data, 32'h1022_0003);
`endif

    // 5: restart at 14, fill the last two words
    start = 1'b1; start_addr = 4'd14;
    tick();
    start = 1'b0;
    check("rs_clear", {27'd0, word_count, full, err}, 32'd0);
    drive(5'd20, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h0);
    tick();
    check("ori_addr", {28'd0, bus.imem_addr}, 32'd14);
    check("ori_data", bus.imem_data, 32'h3422_1234);
    check("ori_full", {31'd0, full}, 32'd0);
    drive(5'd22, 5'd9, 5'd3, 5'd0, 5'd0, 16'hABCD, 26'h0);
    tick();
    check("lui_addr", {28'd0, bus.imem_addr}, 32'd15);
    check("lui_data", bus.imem_data, 32'h3C03_ABCD);
    check("full_set", {31'd0, full}, 32'd1);
    check("full_rdy", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    check("full_nowr", {31'd0, bus.imem_wren}, 32'd0);
    check("full_wc", {27'd0, word_count}, 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd1);
    tick();
    check("done_clr", {31'd0, done}, 32'd0);
    check("idle_rdy", {31'd0, bus.in_ready}, 32'd0);

    // 7: reset the cycle after an accept drops the write
    start = 1'b1; start_addr = 4'd3;
    tick();
    start = 1'b0;
    drive(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_drop", {31'd0, bus.imem_wren}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst2_bus", {27'd0, bus.imem_wren, bus.imem_addr}, 32'd0);
    check("rst2_data", bus.imem_data, 32'd0);
    check("rst2_stat", {23'd0, word_count, full, err, done, bus.in_ready}, 32'd0);
    tick();
    check("rst2_idle", {31'd0, bus.in_ready}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
